// File: rtl/rv_mctl_pkg.sv
// Shared types and encodings for the rv_mctl multicycle control unit.
package rv_mctl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB, MEM_WR,
        ALU_EXEC, ALU_WB, BR_EXEC, JAL_EXEC, JALR_EXEC, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic PC_INC = 1'b0;
    localparam logic PC_ALU = 1'b1;

    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_MDR    = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_L = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ALUA_REG = 2'd0;
    localparam logic [1:0] ALUA_PCC = 2'd1;

    localparam logic ALUB_REG = 1'b0;
    localparam logic ALUB_IMM = 1'b1;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

endpackage

// File: rtl/rv_mctl_wdog.sv
// Memory wait watchdog: counts stalled request cycles within one state and
// flags when the configured limit is reached (limit 0 never expires).
module rv_mctl_wdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at the limit so a held stall cannot wrap back below it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick && count != LIMIT)
            count <= count + CW'(1);
    end

    assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/rv_mctl.sv
// Multicycle RV32 subset control unit: sequences fetch, decode, memory, ALU,
// branch and jump steps and drives the datapath enables and selects.
module rv_mctl
    import rv_mctl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_BR_EXT   = 1'b1,
    parameter bit EN_IALU     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pcsrc,
    output logic        pcwrite,
    output logic        pccen,
    output logic        irwrite,
    output logic        mdrwrite,
    output logic        regwen,
    output logic        bsel,
    output logic [1:0]  wbsel,
    output logic [1:0]  asel,
    output logic [2:0]  immsel,
    output logic [3:0]  alusel,
    output logic        illegal,
    output logic        trap
);
    state_t state, state_nx;
    logic   expired;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       is_lw, is_sw, is_r, is_i, is_br, is_jal, is_jalr, legal;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign bit30  = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_lw   = (opcode == OP_LOAD) && (funct3 == F3_LW);
    assign is_sw   = (opcode == OP_STORE) && (funct3 == F3_SW);
    assign is_r    = (opcode == OP_REG);
    assign is_i    = EN_IALU && (opcode == OP_IMM);
    assign is_br   = (opcode == OP_BRANCH) &&
                     ((funct3 == F3_BEQ) ||
                      (EN_BR_EXT && ((funct3 == F3_BNE) || (funct3 == F3_BLT) || (funct3 == F3_BGE))));
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = EN_IALU && (opcode == OP_JALR) && (funct3 == F3_JALR);
    assign legal   = is_lw | is_sw | is_r | is_i | is_br | is_jal | is_jalr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_nx;
    end

    // Completion wins over timeout when mem_ready lands on the limit cycle.
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:     if (mem_ready) state_nx = DECODE; else if (expired) state_nx = TRAP;
            DECODE: begin
                if (is_lw || is_sw)     state_nx = MEM_ADDR;
                else if (is_r || is_i)  state_nx = ALU_EXEC;
                else if (is_br)         state_nx = BR_EXEC;
                else if (is_jal)        state_nx = JAL_EXEC;
                else if (is_jalr)       state_nx = JALR_EXEC;
                else                    state_nx = FETCH;
            end
            MEM_ADDR:  state_nx = is_sw ? MEM_WR : MEM_RD;
            MEM_RD:    if (mem_ready) state_nx = LW_WB; else if (expired) state_nx = TRAP;
            LW_WB:     state_nx = FETCH;
            MEM_WR:    if (mem_ready) state_nx = FETCH; else if (expired) state_nx = TRAP;
            ALU_EXEC:  state_nx = ALU_WB;
            ALU_WB:    state_nx = FETCH;
            BR_EXEC:   state_nx = FETCH;
            JAL_EXEC:  state_nx = FETCH;
            JALR_EXEC: state_nx = FETCH;
            TRAP:      state_nx = TRAP;
            default:   state_nx = FETCH;
        endcase
    end

    rv_mctl_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_nx != state),
        .tick    (mem_req && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        pcsrc    = PC_INC;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        mdrwrite = 1'b0;
        regwen   = 1'b0;
        bsel     = ALUB_REG;
        wbsel    = WB_PC;
        asel     = ALUA_REG;
        immsel   = IMM_B;
        alusel   = ALU_ADD;
        illegal  = 1'b0;
        trap     = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        pccen   = 1'b1;
                    end
                end
                DECODE: begin
                    asel    = ALUA_PCC;
                    bsel    = ALUB_IMM;
                    illegal = !legal;
                end
                MEM_ADDR: begin
                    bsel   = ALUB_IMM;
                    immsel = is_sw ? IMM_S : IMM_L;
                end
                MEM_RD: begin
                    mem_req  = 1'b1;
                    mdrwrite = mem_ready;
                end
                LW_WB: begin
                    wbsel  = WB_MDR;
                    regwen = 1'b1;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                ALU_EXEC: begin
                    if (opcode == OP_REG) begin
                        alusel = {funct3, bit30};
                    end else begin
                        bsel   = ALUB_IMM;
                        immsel = IMM_I;
                        alusel = {funct3, (funct3 == F3_SR) ? bit30 : 1'b0};
                    end
                end
                ALU_WB: begin
                    wbsel  = WB_ALUOUT;
                    regwen = 1'b1;
                end
                BR_EXEC: begin
                    alusel = ALU_SUB;
                    pcsrc  = PC_ALU;
                    case (funct3)
                        F3_BEQ:  pcwrite = zero;
                        F3_BNE:  pcwrite = !zero;
                        F3_BLT:  pcwrite = lt;
                        F3_BGE:  pcwrite = !lt;
                        default: pcwrite = 1'b0;
                    endcase
                end
                JAL_EXEC: begin
                    immsel  = IMM_J;
                    asel    = ALUA_PCC;
                    bsel    = ALUB_IMM;
                    pcsrc   = PC_ALU;
                    pcwrite = 1'b1;
                    regwen  = 1'b1;
                end
                JALR_EXEC: begin
                    immsel  = IMM_I;
                    bsel    = ALUB_IMM;
                    pcsrc   = PC_ALU;
                    pcwrite = 1'b1;
                    regwen  = 1'b1;
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
